dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU / debug-port arbiter onto a 1W/1R data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_cea,
  output logic [ADDR_W-1:0] mem_ada,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ceb,
  output logic [ADDR_W-1:0] mem_adb,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_oce,
  output logic              mem_rst
);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t            r_state;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic              r_win_rd;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_grant;
  logic              w_sel_dbg;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

`ifdef DMEM_ARB_RR_EN
  logic r_last_dbg;

  // On a tie the requester that did not win last time goes first
  assign w_sel_dbg = (cpu_req & dbg_req) ? ~r_last_dbg : dbg_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_dbg <= 1'b1;
    end else if (w_grant) begin
      r_last_dbg <= w_sel_dbg;
    end
  end
`else
  assign w_sel_dbg = ~cpu_req;
`endif

  assign w_grant = (r_state == S_IDLE) & (cpu_req | dbg_req) & ~rst;

  assign w_we    = w_sel_dbg ? dbg_we    : cpu_we;
  assign w_addr  = w_sel_dbg ? dbg_addr  : cpu_addr;
  assign w_wdata = w_sel_dbg ? dbg_wdata : cpu_wdata;

  assign mem_cea = w_grant & w_we;
  assign mem_ceb = w_grant & ~w_we;
  assign mem_ada = mem_cea ? w_addr  : '0;
  assign mem_din = mem_cea ? w_wdata : '0;
  assign mem_adb = mem_ceb ? w_addr  : '0;
  assign mem_oce = 1'b1;
  assign mem_rst = rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_win_rd  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_ACK;
            r_cpu_ack <= ~w_sel_dbg;
            r_dbg_ack <= w_sel_dbg;
            r_win_rd  <= ~w_we;
          end
        end
        S_ACK: begin
          r_state   <= S_IDLE;
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
          r_win_rd  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data bypasses mem_dout in the ack cycle, then is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (r_cpu_ack & r_win_rd) r_cpu_rdata <= mem_dout;
      if (r_dbg_ack & r_win_rd) r_dbg_rdata <= mem_dout;
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = (r_cpu_ack & r_win_rd) ? mem_dout : r_cpu_rdata;
  assign dbg_rdata = (r_dbg_ack & r_win_rd) ? mem_dout : r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: transaction-level model of the arbiter plus a memory
// fixture; directed phases followed by random two-master traffic.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    gap;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          mem_cea, mem_ceb, mem_oce, mem_rst;
  logic [AW-1:0] mem_ada, mem_adb;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_cea(mem_cea), .mem_ada(mem_ada), .mem_din(mem_din),
    .mem_ceb(mem_ceb), .mem_adb(mem_adb), .mem_dout(mem_dout),
    .mem_oce(mem_oce), .mem_rst(mem_rst)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory fixture: registered read, data valid the cycle after mem_ceb
  logic [DW-1:0] fx_mem [256];
  always @(posedge clk) begin
    if (mem_cea) fx_mem[mem_ada] <= mem_din;
    if (mem_ceb) mem_dout <= fx_mem[mem_adb];
  end

  // Master drivers
  txn_t cq[$];
  txn_t dq[$];
  int   n_txn = 0;
  bit   cp = 0, dp = 0, cskip, dskip;
  int   cw = 0, dw = 0;

  task automatic push(input int m, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.gap = 4'(gap);
    if (m == 0) cq.push_back(t);
    else dq.push_back(t);
    n_txn++;
  endtask

  always @(posedge clk) begin
    #2;
    cskip = 0;
    if (cp && cpu_ack) begin
      void'(cq.pop_front());
      cp = 0; cskip = 1;
      cw = (cq.size() > 0) ? int'(cq[0].gap) : 0;
    end
    if (!cp && cq.size() > 0) begin
      if (cw == 0) begin
        cp = 1; cpu_req = 1'b1; cpu_we = cq[0].we;
        cpu_addr = cq[0].addr; cpu_wdata = cq[0].data;
      end else if (!cskip) cw--;
    end
    if (!cp) begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    end
    dskip = 0;
    if (dp && dbg_ack) begin
      void'(dq.pop_front());
      dp = 0; dskip = 1;
      dw = (dq.size() > 0) ? int'(dq[0].gap) : 0;
    end
    if (!dp && dq.size() > 0) begin
      if (dw == 0) begin
        dp = 1; dbg_req = 1'b1; dbg_we = dq[0].we;
        dbg_addr = dq[0].addr; dbg_wdata = dq[0].data;
      end else if (!dskip) dw--;
    end
    if (!dp) begin
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    end
  end

  // Reference model: a server that takes one request, answers it next
  // cycle, then becomes free; reads return the last value written.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] m_held [2];
  bit            run = 0;
  bit            m_busy = 0;
  int            m_win = 0, m_last = 1;
  bit            m_rd = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_acks [2];
  int            cyc = 0;
  int            g_cyc [2];
  int            a_cyc [2];
  logic [DW-1:0] a_data [2];
  int            gseq[$];
  int            gwe[$];

  always @(negedge clk) begin
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd, act_rd;
    int            w;
    if (run) begin
      chk("cea_ceb_excl", 32'(mem_cea & mem_ceb), 0);
      if (rst) begin
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_dbg_ack", 32'(dbg_ack), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_dbg_rdata", 32'(dbg_rdata), 0);
        chk("rst_mem_ce", {mem_cea, mem_ceb}, 0);
        chk("rst_mem_rst", 32'(mem_rst), 1);
        m_busy = 0; m_last = 1;
        m_held[0] = '0; m_held[1] = '0;
      end else if (m_busy) begin
        exp_rd = m_rd ? ref_mem[m_addr] : m_held[m_win];
        act_rd = (m_win == 1) ? dbg_rdata : cpu_rdata;
        chk("ack_cpu", 32'(cpu_ack), (m_win == 0) ? 1 : 0);
        chk("ack_dbg", 32'(dbg_ack), (m_win == 1) ? 1 : 0);
        chk("ack_rdata", 32'(act_rd), 32'(exp_rd));
        chk("ack_other_rdata",
            32'((m_win == 1) ? cpu_rdata : dbg_rdata),
            32'(m_held[1-m_win]));
        chk("ack_mem_idle",
            {mem_cea, mem_ceb, mem_ada, mem_adb, mem_din}, 0);
        chk("oce", 32'(mem_oce), 1);
        m_held[m_win] = exp_rd;
        m_acks[m_win]++;
        a_cyc[m_win] = cyc;
        a_data[m_win] = act_rd;
        m_busy = 0;
      end else begin
        chk("idle_acks", {cpu_ack, dbg_ack}, 0);
        chk("idle_cpu_rdata", 32'(cpu_rdata), 32'(m_held[0]));
        chk("idle_dbg_rdata", 32'(dbg_rdata), 32'(m_held[1]));
        if (cpu_req || dbg_req) begin
`ifdef DMEM_ARB_RR_EN
          w = (cpu_req && dbg_req) ? 1 - m_last : (dbg_req ? 1 : 0);
`else
          w = cpu_req ? 0 : 1;
`endif
          we = (w == 1) ? dbg_we : cpu_we;
          a  = (w == 1) ? dbg_addr : cpu_addr;
          d  = (w == 1) ? dbg_wdata : cpu_wdata;
          chk("grant_cea", 32'(mem_cea), 32'(we));
          chk("grant_ceb", 32'(mem_ceb), 32'(!we));
          chk("grant_ada", 32'(mem_ada), we ? 32'(a) : 0);
          chk("grant_din", 32'(mem_din), we ? 32'(d) : 0);
          chk("grant_adb", 32'(mem_adb), we ? 0 : 32'(a));
          if (we) ref_mem[a] = d;
          m_busy = 1; m_win = w; m_rd = !we; m_addr = a; m_last = w;
          g_cyc[w] = cyc;
          gseq.push_back(w);
          gwe.push_back(int'(mem_cea));
        end else begin
          chk("idle_mem", {mem_cea, mem_ceb, mem_ada, mem_adb, mem_din}, 0);
        end
      end
      cyc++;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while ((cq.size() > 0 || dq.size() > 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout after %0d cycles", name, k);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string name, input int e[$]);
    chk({name, "_len"}, 32'(gseq.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < gseq.size(); i++)
      chk(name, 32'(gseq[i]), 32'(e[i]));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int e[$];
    int acks0, k;
    for (int i = 0; i < 256; i++) begin
      fx_mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_held[0] = '0; m_held[1] = '0;
    m_acks[0] = 0; m_acks[1] = 0;
    #1 rst = 1'b1;
    #1 run = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // CPU write then read back
    gseq.delete(); gwe.delete();
    push(0, 1'b1, 8'h12, 16'hBEEF, 0);
    push(0, 1'b0, 8'h12, 16'h0000, 0);
    wait_done("wr_rd", 50);
    e = '{0, 0};
    chk_seq("wr_rd_seq", e);
    chk("wr_grant_cea", 32'(gwe[0]), 1);
    chk("rd_grant_cea", 32'(gwe[1]), 0);
    chk("rd_latency", 32'(a_cyc[0] - g_cyc[0]), 1);
    chk("rd_beef", 32'(a_data[0]), 32'h0000BEEF);

    // Preload, then both masters read concurrently
    push(1, 1'b1, 8'h01, 16'hA5A5, 0);
    push(1, 1'b1, 8'h02, 16'h5A5A, 0);
    wait_done("preload", 50);
    gseq.delete();
    for (int i = 0; i < 3; i++) begin
`ifdef DMEM_ARB_RR_EN
      push(0, 1'b0, 8'h01, 16'h0, 0);
`else
      push(0, 1'b0, 8'h01, 16'h0, 1);
`endif
      push(1, 1'b0, 8'h02, 16'h0, 0);
    end
    wait_done("alt", 100);
    e = '{0, 1, 0, 1, 0, 1};
    chk_seq("alt_seq", e);
    chk("alt_cpu_data", 32'(a_data[0]), 32'h0000A5A5);
    chk("alt_dbg_data", 32'(a_data[1]), 32'h00005A5A);
    chk("alt_dbg_latency", 32'(a_cyc[1] - g_cyc[1]), 1);

    // Both requests rise together right after reset
    do_reset();
    gseq.delete();
    for (int i = 0; i < 3; i++) push(0, 1'b0, 8'h01, 16'h0, 0);
    push(1, 1'b0, 8'h02, 16'h0, 0);
    wait_done("prio", 100);
`ifdef DMEM_ARB_RR_EN
    e = '{0, 1, 0, 0};
`else
    e = '{0, 0, 0, 1};
`endif
    chk_seq("prio_seq", e);

    // Reset landing in the ack cycle of a debug read
    acks0 = m_acks[1];
    push(1, 1'b0, 8'h02, 16'h0, 0);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!(m_busy && m_win == 1) && k < 20);
    if (k >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL rst_ack: grant not seen in %0d cycles", k);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wait_done("rst_ack", 50);
    chk("rst_ack_count", 32'(m_acks[1] - acks0), 1);
    chk("rst_ack_data", 32'(a_data[1]), 32'h00005A5A);

    // Random traffic from both masters
    for (int i = 0; i < 40; i++) begin
      push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
           16'($urandom), $urandom_range(0, 2));
      push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
           16'($urandom), $urandom_range(0, 2));
    end
    wait_done("random", 2000);
    chk("total_acks", 32'(m_acks[0] + m_acks[1]), 32'(n_txn));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
